// File: rtl/dfd_list_sched.sv
// Round-robin scheduler sharing one list-producing dfd_* function between N requesters.
// Grants one requester, runs the call handshake, then streams elements to it with back-pressure.
module dfd_list_sched #(
    parameter int N       = 2,
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic            CLOCK_50,
    input  logic            reset,
    input  logic [N-1:0]    cl_start,
    input  logic [N*AW-1:0] cl_arg0,
    input  logic [N*AW-1:0] cl_arg1,
    output logic [N-1:0]    cl_busy,
    output logic [DW-1:0]   cl_value,
    output logic [N-1:0]    cl_valid,
    input  logic [N-1:0]    cl_take,
    output logic [N-1:0]    cl_last,
    output logic [N-1:0]    cl_err,
    output logic            fn_ready,
    input  logic            fn_done,
    output logic [AW-1:0]   fn_arg0,
    output logic [AW-1:0]   fn_arg1,
    output logic            fn_req,
    input  logic            fn_ack,
    input  logic [DW-1:0]   fn_value,
    input  logic            fn_value_valid
);
    localparam int IW  = (N > 1) ? $clog2(N) : 1;
    localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {IDLE, CALL, FETCH, DELIVER, FINISH} state_t;

    state_t        state;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] owner;
    logic [IW-1:0] pick;
    logic          pick_any;
    int unsigned   cand;
    logic [WDW-1:0] wd;
    logic [WDW:0]   wd_inc;
    logic           wd_expired;

    function automatic logic [N-1:0] hot(input logic [IW-1:0] i);
        hot = '0;
        hot[i] = 1'b1;
    endfunction

    // First pending requester at or above rr_ptr, wrapping past N-1.
    always_comb begin
        pick     = '0;
        pick_any = 1'b0;
        cand     = 0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= N) cand = cand - N;
            if (!pick_any && cl_start[cand[IW-1:0]]) begin
                pick     = cand[IW-1:0];
                pick_any = 1'b1;
            end
        end
    end

    always_comb begin
        wd_inc     = {1'b0, wd} + {{WDW{1'b0}}, 1'b1};
        wd_expired = (TIMEOUT != 0) && (wd_inc == (WDW+1)'(TIMEOUT));
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            owner    <= '0;
            wd       <= '0;
            cl_busy  <= '0;
            cl_valid <= '0;
            cl_last  <= '0;
            cl_err   <= '0;
            cl_value <= '0;
            fn_ready <= 1'b0;
            fn_req   <= 1'b0;
            fn_arg0  <= '0;
            fn_arg1  <= '0;
        end else begin
            // Watchdog ticks only while waiting on the function; each transition below clears it.
            if ((state == CALL || state == FETCH) && !(&wd))
                wd <= wd_inc[WDW-1:0];
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        owner    <= pick;
                        fn_arg0  <= cl_arg0[int'(pick)*AW +: AW];
                        fn_arg1  <= cl_arg1[int'(pick)*AW +: AW];
                        cl_busy  <= hot(pick);
                        fn_ready <= 1'b1;
                        wd       <= '0;
                        state    <= CALL;
                    end
                end
                CALL: begin
                    if (fn_done) begin
                        fn_req <= 1'b1;
                        wd     <= '0;
                        state  <= FETCH;
                    end else if (wd_expired) begin
                        cl_err <= hot(owner);
                        wd     <= '0;
                        state  <= FINISH;
                    end
                end
                FETCH: begin
                    if (fn_ack) begin
                        fn_req <= 1'b0;
                        wd     <= '0;
                        if (fn_value_valid) begin
                            cl_value <= fn_value;
                            cl_valid <= hot(owner);
                            state    <= DELIVER;
                        end else begin
                            cl_last <= hot(owner);
                            state   <= FINISH;
                        end
                    end else if (wd_expired) begin
                        fn_req <= 1'b0;
                        cl_err <= hot(owner);
                        wd     <= '0;
                        state  <= FINISH;
                    end
                end
                DELIVER: begin
                    if (cl_take[owner]) begin
                        cl_valid <= '0;
                        fn_req   <= 1'b1;
                        wd       <= '0;
                        state    <= FETCH;
                    end
                end
                FINISH: begin
                    cl_last  <= '0;
                    cl_err   <= '0;
                    cl_busy  <= '0;
                    fn_ready <= 1'b0;
                    wd       <= '0;
                    rr_ptr   <= (owner == IW'(N - 1)) ? '0 : owner + IW'(1);
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/dfd_list_sched.md
# dfd_list_sched

Round-robin scheduler that shares one H2V-generated list-producing function instance (`dfd_*` with call and list-stream ports) between N requesters. It grants a requester, drives the function's call handshake with that requester's arguments, then pulls list elements one at a time over the function's req/ack stream and forwards each to the granted requester with back-pressure. It sits between the board-level top (fed by `CLOCK_50`) and the shared `dfd_*` instance, replacing per-requester instances of the function.

## Interface

- N, default 2: number of requesters (2..8).
- AW, default 8: width of each function argument.
- DW, default 8: width of a list element.
- TIMEOUT, default 1023: maximum cycles to wait for `fn_done` or `fn_ack`; 0 disables the watchdog.

- CLOCK_50  in  1  sole clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cl_start  in  N  requester i asks for a call; level, held until `cl_busy[i]` rises.
- cl_arg0  in  N*AW  first argument of requester i, slice [i*AW +: AW]; held while `cl_start[i]`.
- cl_arg1  in  N*AW  second argument, same packing.
- cl_busy  out  N  one-hot, i owns the function.
- cl_value  out  DW  current element (shared by all requesters).
- cl_valid  out  N  one-hot, element for requester i present on `cl_value`.
- cl_take  in  N  requester i accepts the element this cycle.
- cl_last  out  N  one-cycle pulse, list of requester i ended normally.
- cl_err  out  N  one-cycle pulse, call of requester i aborted by watchdog.
- fn_ready  out  1  call request to the function (level).
- fn_done  in  1  function has accepted the call / stream is available.
- fn_arg0  out  AW  argument 0 to the function.
- fn_arg1  out  AW  argument 1 to the function.
- fn_req  out  1  request next list element.
- fn_ack  in  1  element response present.
- fn_value  in  DW  element data.
- fn_value_valid  in  1  with `fn_ack`: 1 = element, 0 = end of list.

## Operation

- States: IDLE, CALL, FETCH, DELIVER, FINISH.
- IDLE: if any `cl_start` high, pick the first set bit searching upward from `rr_ptr` (wrapping); latch its index and arguments into `fn_arg0/1`; set `cl_busy[i]`; go to CALL. Otherwise stay.
- CALL: `fn_ready`=1. On `fn_done`=1 go to FETCH.
- FETCH: `fn_req`=1. On `fn_ack`=1: if `fn_value_valid`=1 latch `fn_value` into `cl_value`, go to DELIVER; else go to FINISH with normal termination.
- DELIVER: `cl_valid[i]`=1, `fn_req`=0. On `cl_take[i]`=1 go to FETCH.
- FINISH: one cycle. Pulse `cl_last[i]` (normal) or `cl_err[i]` (timeout); clear `cl_busy`, drop `fn_ready`; `rr_ptr` = (i+1) mod N; return to IDLE.
- Watchdog: counter cleared on every state entry, counts in CALL and FETCH only; reaching TIMEOUT goes to FINISH with error. Width ceil(log2(TIMEOUT+1)); saturates, never wraps.
- `fn_ready` stays 1 from CALL through FINISH exit (the call is live for the whole stream).
- `cl_take` of a non-granted requester, or while `cl_valid` low, is ignored. Requester withdrawing `cl_start` after grant does not cancel the call.
- Reset: state IDLE, `rr_ptr`=0, counters 0; all outputs 0 (`cl_busy`, `cl_valid`, `cl_last`, `cl_err`, `fn_ready`, `fn_req`, `cl_value`, `fn_arg0/1`). Reset mid-stream abandons the list with no `cl_last`/`cl_err` pulse; the function sees `fn_ready` fall on the next cycle.

## Timing

- All outputs registered.
- `cl_start` sampled at edge k -> `cl_busy`, `fn_ready`, `fn_arg*` high after edge k+1 (1-cycle grant latency).
- `fn_done` sampled at edge m -> `fn_req` high after m+1.
- `fn_ack` & `fn_value_valid` at edge p -> `cl_valid` and `cl_value` valid after p+1; `fn_req` low after p+1.
- `cl_take` at edge q -> `cl_valid` low and `fn_req` high after q+1. Minimum 2 cycles per element with zero-wait function and consumer.
- End-of-list ack at edge p -> `cl_last` pulse after p+1, `cl_busy` low after p+2; next grant at earliest p+3.
- Simultaneous starts: exactly one grant; others wait in IDLE, starts held.

## Test plan

- Single requester 0, args (1,2), function returns list [5,7] then end -> `cl_value`=5 then 7 on `cl_valid[0]`, then one `cl_last[0]` pulse; `fn_arg0`=1, `fn_arg1`=2 throughout.
- N=2, both `cl_start` high at same edge after reset -> requester 0 served fully, then 1; repeat both -> requester 0 served first again only after `rr_ptr` wrap (1 then 0 on a third start sequence with 1 asserted alone in between verified).
- Empty list: first `fn_ack` with `fn_value_valid`=0 -> no `cl_valid`, `cl_last[i]` pulse 1 cycle after ack.
- Back-pressure: hold `cl_take` low 10 cycles -> `cl_value` stable, `fn_req` stays 0 for all 10 cycles, no element lost or duplicated.
- Watchdog: TIMEOUT=15, `fn_done` never asserted -> `cl_err[i]` pulses after 15 cycles in CALL, `fn_ready` falls, next requester granted.
- Reset asserted during DELIVER -> next cycle all outputs 0, no `cl_last`/`cl_err`, fresh start after release granted to requester 0 first.
